// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a hardware return-address stack.
//
// Provides the fetch address for the 8-bit RISC core. Supports sequential
// increment, unconditional jump, jump-if-zero, call/return through a LIFO
// return-address stack, a pipeline stall, a configurable reset vector and a
// sticky stack overflow/underflow flag.
//
// Optional feature (macro PC_IRQ_EN): adds irq/eoi inputs and an irq_ack
// output. An accepted interrupt pushes the un-executed PC, vectors to
// IRQ_VEC and masks further interrupts until eoi re-enables them.
//
// Priority (highest first):
//   reset > stall > [irq entry] > ret > call > jump > jump_zero&&zero_flag > +1

module pc_stack_unit #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(8'hF0)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          jump,
    input  logic                          jump_zero,
    input  logic                          zero_flag,
    input  logic                          call,
    input  logic                          ret,
    input  logic [ADDR_W-1:0]             jump_addr,
`ifdef PC_IRQ_EN
    input  logic                          irq,
    input  logic                          eoi,
    output logic                          irq_ack,
`endif
    output logic [ADDR_W-1:0]             current_pc,
    output logic [$clog2(STACK_DEPTH):0]  stack_level,
    output logic                          stack_err
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0]  LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Sequential successor of an address; wraps silently at all-ones.
    function automatic logic [ADDR_W-1:0] pc_next_seq(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1'b1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              err_q;
    logic              err_d;

    // Return-address storage; entries at or above level_q are stale.
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    // Stack write request produced by the next-state logic.
    logic              push_en_s;
    logic [ADDR_W-1:0] push_data_s;
    logic [PTR_W-1:0]  push_idx_s;
    logic [PTR_W-1:0]  top_idx_s;
    logic [ADDR_W-1:0] top_entry_s;
    logic              stack_full_s;
    logic              stack_empty_s;
    logic              take_jz_s;

`ifdef PC_IRQ_EN
    logic              ie_q;
    logic              ie_d;
    logic              ack_q;
    logic              ack_d;
    logic              take_irq_s;
`endif

    // ------------------------------------------------------------------
    // Stack addressing
    // ------------------------------------------------------------------

    // Derive stack status, the write slot and the current top entry.
    always_comb begin
        stack_full_s  = (level_q == LVL_FULL);
        stack_empty_s = (level_q == LVL_ZERO);
        // When the stack is not full, level_q fits in PTR_W bits and is the
        // next free slot. When full its low bits are zero, and the top index
        // below still wraps correctly to STACK_DEPTH-1.
        push_idx_s    = level_q[PTR_W-1:0];
        top_idx_s     = level_q[PTR_W-1:0] - PTR_ONE;
        top_entry_s   = stack_q[top_idx_s];
        take_jz_s     = jump_zero & zero_flag;
`ifdef PC_IRQ_EN
        take_irq_s    = irq & ie_q & ~stall & ~stack_full_s;
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Resolve the strobes in priority order into PC, stack and flag updates.
    always_comb begin
        pc_d        = pc_q;
        level_d     = level_q;
        err_d       = err_q;
        push_en_s   = 1'b0;
        push_data_s = pc_next_seq(pc_q);
`ifdef PC_IRQ_EN
        ie_d        = ie_q;
        ack_d       = 1'b0;
`endif

        if (stall) begin
            // Freeze everything; all other strobes are ignored.
            pc_d    = pc_q;
            level_d = level_q;
            err_d   = err_q;
        end
`ifdef PC_IRQ_EN
        else if (take_irq_s) begin
            // Interrupt entry: the current PC has not executed yet, so it is
            // the return point. All other strobes are dropped this cycle.
            push_en_s   = 1'b1;
            push_data_s = pc_q;
            level_d     = level_q + LVL_ONE;
            pc_d        = IRQ_VEC;
            ie_d        = 1'b0;
            ack_d       = 1'b1;
        end
`endif
        else begin
`ifdef PC_IRQ_EN
            // End-of-interrupt re-enables entry; may coincide with ret.
            if (eoi) begin
                ie_d = 1'b1;
            end else begin
                ie_d = ie_q;
            end
`endif
            if (ret) begin
                if (!stack_empty_s) begin
                    pc_d    = top_entry_s;
                    level_d = level_q - LVL_ONE;
                end else begin
                    // Underflow: flag it and carry on sequentially.
                    err_d   = 1'b1;
                    pc_d    = pc_next_seq(pc_q);
                end
            end else if (call) begin
                if (!stack_full_s) begin
                    push_en_s   = 1'b1;
                    push_data_s = pc_next_seq(pc_q);
                    level_d     = level_q + LVL_ONE;
                end else begin
                    // Overflow: the return address is lost, call degrades
                    // to a plain jump.
                    err_d       = 1'b1;
                end
                pc_d = jump_addr;
            end else if (jump) begin
                pc_d = jump_addr;
            end else if (take_jz_s) begin
                pc_d = jump_addr;
            end else begin
                pc_d = pc_next_seq(pc_q);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // PC, stack level and sticky error, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            level_q <= LVL_ZERO;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Return-address storage; contents need no reset because level_q
    // marks which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en_s && !reset) begin
            stack_q[push_idx_s] <= push_data_s;
        end
    end

`ifdef PC_IRQ_EN
    // Interrupt enable and one-cycle acknowledge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q  <= 1'b1;
            ack_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            ack_q <= ack_d;
        end
    end

    assign irq_ack = ack_q;
`endif

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign current_pc  = pc_q;
    assign stack_level = level_q;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit (default parameters).
// Directed vector table, hand-written reset sequences and randomized
// stimulus compared against a queue-based reference model.

module tb_pc_stack_unit;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       stall      = 1'b0;
    logic       jump       = 1'b0;
    logic       jump_zero  = 1'b0;
    logic       zero_flag  = 1'b0;
    logic       call       = 1'b0;
    logic       ret        = 1'b0;
    logic [7:0] jump_addr  = 8'h00;
    logic [7:0] current_pc;
    logic [2:0] stack_level;
    logic       stack_err;
`ifdef PC_IRQ_EN
    logic       irq        = 1'b0;
    logic       eoi        = 1'b0;
    logic       irq_ack;
`endif

    pc_stack_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump        (jump),
        .jump_zero   (jump_zero),
        .zero_flag   (zero_flag),
        .call        (call),
        .ret         (ret),
        .jump_addr   (jump_addr),
`ifdef PC_IRQ_EN
        .irq         (irq),
        .eoi         (eoi),
        .irq_ack     (irq_ack),
`endif
        .current_pc  (current_pc),
        .stack_level (stack_level),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: PC as an integer, stack as a queue (back = top).
    int         m_pc;
    logic [7:0] m_stk [$];
    bit         m_err;

    // Directed vector: ctl = {stall, jump, jump_zero, zero_flag, call, ret}.
    typedef struct {
        logic [5:0] ctl;
        logic [7:0] addr;
        logic [7:0] pc;
        int         lvl;
        logic       err;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [7:0] addr,
                                input logic [7:0] pc, input int lvl, input logic err);
        vec_t v;
        v.ctl = ctl; v.addr = addr; v.pc = pc; v.lvl = lvl; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] ctl, input logic [7:0] a);
        if (ctl[5]) begin
            // stall: nothing changes
        end else if (ctl[0]) begin
            if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
            else begin m_err = 1'b1; m_pc = (m_pc + 1) % 256; end
        end else if (ctl[1]) begin
            if (m_stk.size() < 4) m_stk.push_back(8'((m_pc + 1) % 256));
            else m_err = 1'b1;
            m_pc = int'(a);
        end else if (ctl[4] || (ctl[3] && ctl[2])) begin
            m_pc = int'(a);
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [7:0] a);
        {stall, jump, jump_zero, zero_flag, call, ret} = ctl;
        jump_addr = a;
    endtask

    task automatic check_model(input string nm);
        chk({nm, "_pc"},  int'(current_pc),  m_pc);
        chk({nm, "_lvl"}, int'(stack_level), m_stk.size());
        chk({nm, "_err"}, int'(stack_err),   int'(m_err));
    endtask

    initial begin
        // Directed vectors, starting from reset (pc=0).
        tbl[0]  = mk(6'b000000, 8'h00, 8'h01, 0, 1'b0);
        tbl[1]  = mk(6'b000000, 8'h00, 8'h02, 0, 1'b0);
        tbl[2]  = mk(6'b000000, 8'h00, 8'h03, 0, 1'b0);
        tbl[3]  = mk(6'b000010, 8'h20, 8'h20, 1, 1'b0);  // call from 3
        tbl[4]  = mk(6'b000000, 8'h00, 8'h21, 1, 1'b0);
        tbl[5]  = mk(6'b000010, 8'h30, 8'h30, 2, 1'b0);  // nested call
        tbl[6]  = mk(6'b000001, 8'h00, 8'h22, 1, 1'b0);  // ret
        tbl[7]  = mk(6'b000001, 8'h00, 8'h04, 0, 1'b0);  // ret
        tbl[8]  = mk(6'b000000, 8'h00, 8'h05, 0, 1'b0);
        tbl[9]  = mk(6'b110000, 8'h40, 8'h05, 0, 1'b0);  // stall beats jump
        tbl[10] = mk(6'b011000, 8'h40, 8'h40, 0, 1'b0);  // jump, jz zf=0
        tbl[11] = mk(6'b001000, 8'h77, 8'h41, 0, 1'b0);  // jz not taken
        tbl[12] = mk(6'b001100, 8'hFF, 8'hFF, 0, 1'b0);  // jz taken
        tbl[13] = mk(6'b000000, 8'h00, 8'h00, 0, 1'b0);  // wrap, no error
        tbl[14] = mk(6'b000010, 8'h60, 8'h60, 1, 1'b0);  // pushes 01
        tbl[15] = mk(6'b000010, 8'h61, 8'h61, 2, 1'b0);  // pushes 61
        tbl[16] = mk(6'b000010, 8'h62, 8'h62, 3, 1'b0);  // pushes 62
        tbl[17] = mk(6'b000010, 8'h63, 8'h63, 4, 1'b0);  // pushes 63, full
        tbl[18] = mk(6'b000010, 8'h50, 8'h50, 4, 1'b1);  // overflow
        tbl[19] = mk(6'b000011, 8'h99, 8'h63, 3, 1'b1);  // ret beats call
        tbl[20] = mk(6'b000001, 8'h00, 8'h62, 2, 1'b1);
        tbl[21] = mk(6'b000001, 8'h00, 8'h61, 1, 1'b1);
        tbl[22] = mk(6'b000001, 8'h00, 8'h01, 0, 1'b1);
        tbl[23] = mk(6'b000001, 8'h00, 8'h02, 0, 1'b1);  // underflow
        tbl[24] = mk(6'b100001, 8'h00, 8'h02, 0, 1'b1);  // stall beats ret
        tbl[25] = mk(6'b000000, 8'h00, 8'h03, 0, 1'b1);  // err sticky

        // Reset, release between edges, check reset values.
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_pc",  int'(current_pc),  0);
        chk("reset_lvl", int'(stack_level), 0);
        chk("reset_err", int'(stack_err),   0);

        // Table-driven directed vectors.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].ctl, tbl[i].addr);
            @(posedge clk);
            model_step(tbl[i].ctl, tbl[i].addr);
            #1;
            chk($sformatf("vec%0d_pc", i),  int'(current_pc),  int'(tbl[i].pc));
            chk($sformatf("vec%0d_lvl", i), int'(stack_level), tbl[i].lvl);
            chk($sformatf("vec%0d_err", i), int'(stack_err),   int'(tbl[i].err));
        end

        // Async reset between edges while stalled: clears immediately.
        drive(6'b110000, 8'h40);
        #2;
        reset = 1'b1;
        #1;
        chk("async_pc",  int'(current_pc),  0);
        chk("async_lvl", int'(stack_level), 0);
        chk("async_err", int'(stack_err),   0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // First edge after release still stalled: holds reset vector.
        @(posedge clk);
        model_step(6'b110000, 8'h40);
        #1;
        check_model("post_rst_stall");
        drive(6'b000000, 8'h00);
        @(posedge clk);
        model_step(6'b000000, 8'h00);
        #1;
        check_model("post_rst_inc");

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic [5:0] ctl;
            logic [7:0] a;
            if (c % 100 == 99) begin
                #2;
                reset = 1'b1;
                #1;
                model_reset();
                check_model($sformatf("rnd_rst%0d", c));
                @(negedge clk);
                reset = 1'b0;
            end
            ctl[5] = ($urandom_range(7) == 0);
            ctl[4] = ($urandom_range(7) == 0);
            ctl[3] = ($urandom_range(3) == 0);
            ctl[2] = 1'($urandom_range(1));
            ctl[1] = ($urandom_range(3) == 0);
            ctl[0] = ($urandom_range(3) == 0);
            a      = 8'($urandom_range(255));
            drive(ctl, a);
            @(posedge clk);
            model_step(ctl, a);
            #1;
            check_model($sformatf("rnd%0d", c));
        end

`ifdef PC_IRQ_EN
        // Interrupt entry, masking, and return with eoi.
        drive(6'b000000, 8'h00);
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        drive(6'b010000, 8'h10);
        @(posedge clk); #1;
        chk("irq_pre_pc", int'(current_pc), 16'h10);
        drive(6'b000000, 8'h00);
        irq = 1'b1;
        @(posedge clk); #1;
        chk("irq_entry_pc",  int'(current_pc),  16'hF0);
        chk("irq_entry_ack", int'(irq_ack),     1);
        chk("irq_entry_lvl", int'(stack_level), 1);
        @(posedge clk); #1;
        chk("irq_masked_pc",  int'(current_pc), 16'hF1);
        chk("irq_masked_ack", int'(irq_ack),    0);
        irq = 1'b0;
        eoi = 1'b1;
        drive(6'b000001, 8'h00);
        @(posedge clk); #1;
        chk("irq_ret_pc",  int'(current_pc),  16'h10);
        chk("irq_ret_lvl", int'(stack_level), 0);
        eoi = 1'b0;
        irq = 1'b1;
        drive(6'b000000, 8'h00);
        @(posedge clk); #1;
        chk("irq_reenter_pc",  int'(current_pc), 16'hF0);
        chk("irq_reenter_ack", int'(irq_ack),    1);
        irq = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the 8-bit RISC core, with a hardware return-address stack for call/return.
- Keeps the existing sequential/jump/jump-if-zero modes and adds stall, call, return, configurable reset vector and stack error reporting.
- Sits between the instruction decoder (control strobes, target address) and instruction memory (current_pc as fetch address).

Parameters:
- ADDR_W, 8, width of PC, jump target and stack entries.
- STACK_DEPTH, 4, number of return-address entries (power of two, >= 2).
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).
- IRQ_VEC, 8'hF0, interrupt vector (used only with IRQ_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC, stack and flags this cycle.
- jump  input  1  unconditional jump to jump_addr.
- jump_zero  input  1  jump to jump_addr if zero_flag=1.
- zero_flag  input  1  ALU zero flag.
- call  input  1  push return address, jump to jump_addr.
- ret  input  1  pop stack into PC.
- jump_addr  input  ADDR_W  branch/call target.
- current_pc  output  ADDR_W  registered fetch address.
- stack_level  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset is asynchronous: clk and reset, asynchronous, active-high. Reset values: current_pc=RESET_VEC, stack_level=0, stack_err=0. Stack contents are don't-care.
- All updates happen on the rising clk edge. current_pc is registered, so a control strobe sampled in cycle N takes effect on current_pc in cycle N+1. No other latency.
- Priority, highest first: reset > stall > ret > call > jump > (jump_zero && zero_flag) > increment.
- stall=1: current_pc, stack, stack_level and stack_err all hold; every other strobe is ignored.
- Increment: current_pc+1, modulo 2^ADDR_W. All-ones wraps to 0 with no flag.
- jump, or jump_zero with zero_flag=1: current_pc <= jump_addr. jump_zero with zero_flag=0 increments.
- call with stack_level<STACK_DEPTH:
  - push current_pc+1 (modulo 2^ADDR_W);
  - stack_level+1;
  - current_pc <= jump_addr.
- call with stack full:
  - no push, stack_level unchanged;
  - stack_err <= 1;
  - current_pc <= jump_addr (behaves as a plain jump).
- ret with stack_level>0: current_pc <= top entry, stack_level-1.
- ret with stack empty: stack_err <= 1, current_pc increments, stack_level stays 0.
- Stack is LIFO; entries above stack_level are invalid.
- stack_err is sticky and cleared only by reset.
- Reset asserted mid-operation (including during a stall) clears immediately and asynchronously. The first edge after deassertion applies normal priority starting from RESET_VEC.

Optional Feature:
- Macro: PC_IRQ_EN. Adds ports irq (input, 1), eoi (input, 1) and irq_ack (output, 1, reset 0), plus an internal enable ie (reset 1).
- Interrupt entry, taken when irq && ie && !stall && stack_level<STACK_DEPTH. Priority is above ret. On entry:
  - push current_pc (the un-executed instruction);
  - current_pc <= IRQ_VEC;
  - ie <= 0;
  - irq_ack pulses high for one cycle;
  - all other strobes that cycle are ignored.
- irq with stack full is deferred, not lost, and sets no error.
- eoi=1 (not stalled) sets ie <= 1. eoi may coincide with ret; both take effect.
- Without the macro: no irq/eoi/irq_ack ports and no ie logic; behaviour is exactly as above.

Test Plan:
- Reset and increment: reset pulse, then 3 idle cycles -> current_pc 0,1,2,3. Preload 8'hFF -> next value 8'h00, stack_err=0.
- Stall and priority: at pc=5, stall=1 with jump=1, jump_addr=8'h40 -> pc holds 5. Release with jump and jump_zero both set, zero_flag=0 -> pc=8'h40. Then jump_zero=1, zero_flag=0 -> pc=8'h41.
- Nested call/ret: call 8'h20 at pc=3, then call 8'h30 at pc=8'h21 -> stack_level=2. ret -> pc=8'h22. ret -> pc=4, stack_level=0.
- Overflow: 4 calls fill the stack, then a 5th call to 8'h50 -> pc=8'h50, stack_level=4, stack_err=1. Four rets return in LIFO order.
- Underflow and async reset: ret on empty stack at pc=7 -> pc=8, stack_err=1. Assert reset between clock edges -> pc=RESET_VEC and stack_err=0 immediately.
- PC_IRQ_EN: irq at pc=8'h10 -> pc=8'hF0, irq_ack for 1 cycle, stack holds 8'h10. Second irq is ignored until eoi. ret with eoi -> pc=8'h10, ie=1.
